// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the jacaranda-8 UART receive control
//                block: register addresses, STATUS/CTRL bit positions, FSM
//                state encoding, divisor floor and the divisor clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Register map
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_DIV_LO = 3'd3;
  localparam logic [2:0] ADDR_DIV_HI = 3'd4;

  // STATUS bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_RX_EN     = 3;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // Smallest bit period ever handed to the receiver
  localparam logic [15:0] DIV_MIN = 16'd16;

  // Receiver gating state
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } rx_state_e;

  // Raise a raw divisor to the floor value if it is too small
  function automatic logic [15:0] clamp_div(input logic [15:0] raw,
                                            input logic [15:0] floor_val);
    return (raw < floor_val) ? floor_val : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl_if
//  Description : CPU-side register bus of the UART receive control block.
//  Ports       : addr  - register select (3)
//                wdata - write data (8)
//                we    - one-cycle write strobe
//                re    - one-cycle read strobe
//                rdata - registered read data (8), valid the cycle after re
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic [7:0] rdata;

  modport master (output addr, output wdata, output we, output re, input rdata);
  modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Synchronous FIFO for received bytes. A push while full is
//                accepted only when a pop happens in the same cycle; a pop
//                while empty is refused. Flush overrides push and pop.
//  Ports       : clk, reset_n       - clock, asynchronous active-low reset
//                push, wdata        - write request and data
//                pop, rdata         - read request and head-of-queue data
//                flush              - empty the FIFO
//                full, empty, count - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   C_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // A pop frees the slot a same-cycle push lands in, so full+pop may push.
  assign w_do_push = push & (~full | pop) & ~flush;
  assign w_do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : Control and buffering layer for the UART receiver. Programs
//                the receiver bit period, gates start detection, captures
//                completed bytes into a FIFO and exposes DATA/STATUS/CTRL/DIV
//                registers plus a level interrupt.
//  Ports       : clk, reset_n      - clock, asynchronous active-low reset
//                rx_data           - byte from receiver
//                rx_end_flag       - receiver frame-complete strobe
//                rx_en             - receiver start-detection enable
//                clk_count_bit     - bit period to receiver {16'b0, div}
//                bus               - register bus (slave side)
//                irq               - registered level interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434,
  parameter logic [15:0] DIV_MIN    = uart_pkg::DIV_MIN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_end_flag,
  output logic                 rx_en,
  output logic [31:0]          clk_count_bit,
  uart_rx_ctrl_if.slave        bus,
  output logic                 irq
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             r_rx_end_d;
  logic             r_edge;
  logic             r_enable;
  logic             r_irq_en;
  logic             r_overrun;
  logic             r_irq;
  logic [15:0]      r_div_shadow;
  logic [15:0]      r_div_active;
  logic [7:0]       r_rdata;
  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic             w_rx_en;

  logic             w_ctrl_wr;
  logic             w_flush;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_not_empty;
  logic [CNT_W-1:0] w_count;
  logic [7:0]       w_head;
  logic [7:0]       w_status;

  assign w_ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
  assign w_flush     = w_ctrl_wr && bus.wdata[CTRL_FLUSH];
  assign w_pop       = bus.re && (bus.addr == ADDR_DATA) && !w_empty;
  assign w_push      = r_edge && r_enable;
  // Byte lost only when full and no same-cycle pop makes room.
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_not_empty = (w_count != '0);

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (rx_data),
    .pop     (w_pop),
    .flush   (w_flush),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // Edge detect is registered, so the push lands one cycle after the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_end_d <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_rx_end_d <= rx_end_flag;
      r_edge     <= rx_end_flag & ~r_rx_end_d;
    end
  end

  // Control, shadow divisor and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable     <= 1'b0;
      r_irq_en     <= 1'b0;
      r_overrun    <= 1'b0;
      r_div_shadow <= DIV_RESET;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= bus.wdata[CTRL_ENABLE];
        r_irq_en <= bus.wdata[CTRL_IRQ_EN];
      end
      if (bus.we && (bus.addr == ADDR_DIV_LO)) r_div_shadow[7:0]  <= bus.wdata;
      if (bus.we && (bus.addr == ADDR_DIV_HI)) r_div_shadow[15:8] <= bus.wdata;
      if (w_flush)     r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;
    end
  end

  // Active divisor tracks the shadow only while the receiver is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_active <= DIV_RESET;
    end else if (r_state == ST_OFF) begin
      r_div_active <= clamp_div(r_div_shadow, DIV_MIN);
    end
  end

  always_comb begin
    w_status                 = 8'h00;
    w_status[STAT_NOT_EMPTY] = w_not_empty;
    w_status[STAT_FULL]      = w_full;
    w_status[STAT_OVERRUN]   = r_overrun;
    w_status[STAT_RX_EN]     = w_rx_en;
  end

  // Read data reflects pre-write contents when re and we coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 8'h00;
    end else if (bus.re) begin
      case (bus.addr)
        ADDR_DATA:   r_rdata <= w_empty ? 8'h00 : w_head;
        ADDR_STATUS: r_rdata <= w_status;
        ADDR_CTRL:   r_rdata <= {6'b0, r_irq_en, r_enable};
        ADDR_DIV_LO: r_rdata <= r_div_shadow[7:0];
        ADDR_DIV_HI: r_rdata <= r_div_shadow[15:8];
        default:     r_rdata <= 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= r_irq_en & (w_not_empty | r_overrun);
  end

  // Receiver gating FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_OFF;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rx_en     = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_ctrl_wr && bus.wdata[CTRL_ENABLE]) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_rx_en = 1'b1;
        if (w_ctrl_wr && !bus.wdata[CTRL_ENABLE]) w_state_nxt = ST_OFF;
        else if (w_full)                          w_state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (w_ctrl_wr && !bus.wdata[CTRL_ENABLE]) w_state_nxt = ST_OFF;
        else if (!w_full)                         w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  assign rx_en         = w_rx_en;
  assign clk_count_bit = {16'b0, r_div_active};
  assign bus.rdata     = r_rdata;
  assign irq           = r_irq;

endmodule
`default_nettype wire
